column_drop_engine: RTL
=======================

// Module: column_drop_engine
// PURPOSE
//   Parametrised Connect-4 token-drop engine; generalises the fixed 4x4 column selector to ROWS x COLS.
//   Accepts a column request for the current player and drops the token to the lowest free row.
//   Rejects full or out-of-range columns with a throw_again pulse.
//   Tracks the turn, and publishes the occupancy and ownership boards to the win checker and display.
// PARAMETERS
//   ROWS   6                      board rows; row 0 is the bottom
//   COLS   7                      board columns; column 0 is the leftmost
//   COLW   $clog2(COLS)           width of drop_col
//   HW     $clog2(ROWS+1)         width of each column height counter
// PORTS
//   clk                clk    in   1          system clock, rising edge
//   reset              reset  in   1          asynchronous, active-high; clears all state
//   clear              in     1               synchronous new-game clear
//   drop_valid         in     1               drop request strobe
//   drop_col           in     COLW            requested column
//   drop_ready         out    1               engine is idle and a drop is accepted this cycle
//   drop_done          out    1               1-cycle pulse: token placed
//   throw_again        out    1               1-cycle pulse: request rejected; same player retries
//   out_gameboard      out    ROWS*COLS       occupancy; bit r*COLS+c = 1 when the cell is filled
//   out_players_cells  out    ROWS*COLS       owner; 0=P1, 1=P2; valid only where occupancy = 1
//   next_player        out    1               player to move; 0=P1, 1=P2
//   last_row           out    HW              row of the last placed token
//   last_col           out    COLW            column of the last placed token
//   board_full         out    1               all ROWS*COLS cells occupied
// BEHAVIOUR
//   Reset (async) values:
//     - all boards = 0, next_player = 0, heights = 0, FSM = IDLE.
//     - last_row = 0, last_col = 0; all pulse outputs 0.
//   clear: same effect as reset, but synchronous; clear has priority over every other input.
//   FSM states:
//     - IDLE: drop_ready = 1. On drop_valid, latch drop_col and the current player, go to CHECK.
//     - CHECK: test the latched column.
//         - col >= COLS or height[col] == ROWS -> REJECT.
//         - otherwise -> PLACE.
//     - PLACE:
//         - set occupancy bit height[col]*COLS+col; write the owner bit = latched player.
//         - last_row <= height[col]; last_col <= col; height[col] += 1.
//         - toggle next_player; go to DONE.
//     - DONE: drop_done = 1 for one cycle; board_full updated; go to IDLE.
//     - REJECT: throw_again = 1 for one cycle; board and next_player unchanged; go to IDLE.
//   Latency and handshake:
//     - Accepted drop to drop_done pulse is 3 cycles; a rejected drop gives throw_again 2 cycles after acceptance.
//     - Boards are visible updated in the same cycle that drop_done is high.
//     - drop_valid is ignored whenever drop_ready = 0; there is no queueing.
//   Board full:
//     - board_full = 1 -> every request is rejected via throw_again.
//     - Heights saturate at ROWS and never wrap.
//   Reset or clear asserted mid-operation (CHECK/PLACE/DONE/REJECT):
//     - the pending drop is abandoned; no drop_done or throw_again pulse is produced.
//   Ownership bits of empty cells read as 0.
// TESTING  (ROWS=4, COLS=4 unless stated)
//   1. reset, then drop col 0 -> drop_done after 3 cycles; out_gameboard=16'h0001, players=16'h0000, next_player=1.
//   2. P2 drops col 0 -> gameboard=16'h0011, players=16'h0010, last_row=1, next_player=0.
//   3. Fill col 2 (4 drops); 5th drop col 2 -> throw_again pulse; boards unchanged; next_player unchanged.
//   4. drop_col=5 (COLW=2 wraps; run with COLS=5, request 7) -> throw_again, no board change.
//   5. drop_valid during CHECK -> ignored; only 1 token added.
//      Assert reset during PLACE -> all outputs 0, no drop_done.
//   6. Fill all 16 cells -> board_full=1, gameboard=16'hFFFF; any further drop -> throw_again.
//      clear -> board_full=0, next_player=0.

Source files
------------

// File: rtl/column_drop_engine_if.sv
// Drop-request handshake between a player front end and the column drop engine.
// drop_valid/drop_col are sampled only while drop_ready is high; drop_done and throw_again are single-cycle results.
interface column_drop_engine_if #(
  parameter int COLW = 3
);
  logic            drop_valid;
  logic [COLW-1:0] drop_col;
  logic            drop_ready;
  logic            drop_done;
  logic            throw_again;

  modport master (output drop_valid, drop_col, input drop_ready, drop_done, throw_again);
  modport slave  (input drop_valid, drop_col, output drop_ready, drop_done, throw_again);
endinterface

// File: rtl/column_drop_engine.sv
// Connect-4 token-drop engine: accepts a column request, drops the current player's token
// to the lowest free row of that column, or rejects the request with throw_again.
module column_drop_engine #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int COLW = $clog2(COLS),
  parameter int HW   = $clog2(ROWS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  column_drop_engine_if.slave  drop,
  output logic [ROWS*COLS-1:0] out_gameboard,
  output logic [ROWS*COLS-1:0] out_players_cells,
  output logic                 next_player,
  output logic [HW-1:0]        last_row,
  output logic [COLW-1:0]      last_col,
  output logic                 board_full,
  output logic [2:0]           dbg_state
);
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_PLACE  = 3'd2,
    S_DONE   = 3'd3,
    S_REJECT = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [COLW-1:0] lat_col;
  logic            lat_player;
  // Sized to the full drop_col range so an out-of-range request can never index past the array.
  logic [HW-1:0]   height [2**COLW];
  logic [HW-1:0]   height_sel;
  logic            col_ok;
  logic            col_free;
  logic [31:0]     place_idx;
  logic [CELLS-1:0] place_mask;

  assign height_sel = height[lat_col];
  assign col_ok     = 32'(lat_col) < 32'(COLS);
  assign col_free   = col_ok && (32'(height_sel) < 32'(ROWS)) && !board_full;
  assign place_idx  = 32'(height_sel) * 32'(COLS) + 32'(lat_col);
  assign place_mask = {{(CELLS-1){1'b0}}, 1'b1} << place_idx;
  assign board_full = &out_gameboard;
  assign dbg_state  = state;

  // Pulses are gated by clear so an abandoned drop never reports a result.
  always_comb begin
    state_next       = state;
    drop.drop_ready  = 1'b0;
    drop.drop_done   = 1'b0;
    drop.throw_again = 1'b0;
    case (state)
      S_IDLE: begin
        drop.drop_ready = !clear;
        if (drop.drop_valid) state_next = S_CHECK;
      end
      S_CHECK:  state_next = col_free ? S_PLACE : S_REJECT;
      S_PLACE:  state_next = S_DONE;
      S_DONE: begin
        drop.drop_done = !clear;
        state_next     = S_IDLE;
      end
      S_REJECT: begin
        drop.throw_again = !clear;
        state_next       = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
    if (clear) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_gameboard     <= '0;
      out_players_cells <= '0;
      next_player       <= 1'b0;
      last_row          <= '0;
      last_col          <= '0;
      lat_col           <= '0;
      lat_player        <= 1'b0;
      for (int i = 0; i < 2**COLW; i++) height[i] <= '0;
    end else if (clear) begin
      out_gameboard     <= '0;
      out_players_cells <= '0;
      next_player       <= 1'b0;
      last_row          <= '0;
      last_col          <= '0;
      lat_col           <= '0;
      lat_player        <= 1'b0;
      for (int i = 0; i < 2**COLW; i++) height[i] <= '0;
    end else begin
      if (state == S_IDLE && drop.drop_valid) begin
        lat_col    <= drop.drop_col;
        lat_player <= next_player;
      end
      // Target cell is empty, so its owner bit is still 0 and only a P2 token needs a write.
      if (state == S_PLACE) begin
        out_gameboard <= out_gameboard | place_mask;
        if (lat_player) out_players_cells <= out_players_cells | place_mask;
        last_row        <= height_sel;
        last_col        <= lat_col;
        height[lat_col] <= height_sel + HW'(1);
        next_player     <= ~next_player;
      end
    end
  end
endmodule
